sdram_cmd_responder: RTL and testbench
======================================

// Module: sdram_cmd_responder
// PURPOSE
//  Responder end of the music-box SDRAM command interface that the record/playback states drive.
//  Accepts one command at a time and serves it from on-chip RAM.
//  Returns recievedCommand, isBusy and outputValid/readData with fixed, parameterised latencies.
//  Used as the drop-in SDRAM stand-in for simulation and for FPGA bring-up without the external SDRAM.
// PARAMETERS
//  ADDR_BITS        10   RAM depth = 2**ADDR_BITS words of 16 bits
//  READ_LATENCY     3    cycles from recievedCommand to outputValid (>=1)
//  WRITE_CYCLES     2    busy cycles per write (>=1)
//  REFRESH_INTERVAL 390  cycles between refresh stalls (SDRAM_REFRESH_STALL_EN only)
//  REFRESH_CYCLES   8    busy cycles per refresh stall (SDRAM_REFRESH_STALL_EN only)
// PORTS
//  clock_50Mhz            in   1   sole clock
//  reset_n                in   1   asynchronous, active-low reset
//  sdram_inputAddress     in   25  word address; only bits [ADDR_BITS-1:0] used
//  sdram_writeData        in   16  write data
//  sdram_isWriting        in   1   1 = write, 0 = read
//  sdram_inputValid       in   1   command request; held by initiator until recievedCommand
//  sdram_readData         out  16  read data; valid when sdram_outputValid=1, then held
//  sdram_outputValid      out  1   one-cycle pulse per completed read
//  sdram_recievedCommand  out  1   one-cycle pulse: command accepted
//  sdram_isBusy           out  1   1 = no command will be accepted
// BEHAVIOUR
//  Reset values: all outputs 0; state IDLE; counters 0. RAM contents are not cleared.
//  FSM states: IDLE, WRITE_WAIT, READ_WAIT, REFRESH (REFRESH only with the macro).
//  Accept: sdram_inputValid=1 in IDLE at edge E0 latches address, data and isWriting.
//   - Cycle C1 (after E0): recievedCommand=1 and isBusy=1.
//  Write: RAM written at edge E0.
//   - isBusy=1 for C1..C(WRITE_CYCLES); IDLE, isBusy=0 in C(WRITE_CYCLES+1).
//  Read: RAM read is registered; outputValid=1 and readData=RAM[addr] in C(1+READ_LATENCY).
//   - isBusy=1 for C1..C(READ_LATENCY); isBusy=0 in the outputValid cycle.
//   - A new command can therefore be accepted at the end of the outputValid cycle.
//  inputValid while busy: ignored, never queued; no recievedCommand.
//  Back-to-back: inputValid held continuously gives one acceptance per IDLE entry.
//  Address wrap: addr mod 2**ADDR_BITS; 25'h1_FFFF_FF aliases to (2**ADDR_BITS)-1.
//  readData keeps the last read value through writes and idle; updates only with outputValid.
//  Read-after-write to the same address returns the new data.
//  Reset mid-operation aborts the command: pending outputValid is dropped, outputs return to 0.
//   - A write accepted before reset remains in RAM.
// CONFIGURATION
//  SDRAM_REFRESH_STALL_EN defined:
//   - Free-running counter raises refresh-pending every REFRESH_INTERVAL cycles.
//   - Refresh is taken only from IDLE and wins over a simultaneous inputValid.
//   - REFRESH holds isBusy=1 for REFRESH_CYCLES with no recievedCommand, then returns to IDLE.
//   - Pending is held (not lost) while a command is in progress.
//  Undefined: no REFRESH state; isBusy reflects command activity only.
// STRUCTURE
//  Package music_box_sdram_pkg:
//   - SDRAM_ADDR_W=25, SDRAM_DATA_W=16
//   - typedef enum sdram_resp_state_t {IDLE, WRITE_WAIT, READ_WAIT, REFRESH}
//  Sub-module sdram_model_ram: single-port synchronous RAM (1 write or 1 registered read per cycle).
//  Top level holds the FSM, latency/busy counter and refresh counter.
// TESTING
//  1. Write 0xBEEF @0x10, then read 0x10.
//     -> recievedCommand each C1; outputValid in C4 (default latency 3); readData=0xBEEF.
//  2. inputValid held high during the write-busy window.
//     -> exactly 1 recievedCommand; second command accepted only after isBusy falls.
//  3. Write 0x1234 @0x0000400 with ADDR_BITS=10, read @0x0000000 -> readData=0x1234 (wrap).
//  4. Assert reset_n=0 in C2 of a read -> no outputValid; all outputs 0.
//     -> A later read of a pre-reset write returns its data.
//  5. Macro on: inputValid rises in the same cycle refresh becomes due.
//     -> isBusy 8 cycles, no ack; command acked after refresh.
//  6. 256 random reads/writes vs a scoreboard model -> all read data match; 1 ack per command.

Source files
------------

// File: rtl/music_box_sdram_pkg.sv
// rtl/music_box_sdram_pkg.sv - shared widths, responder state type and helpers for the SDRAM stand-in
package music_box_sdram_pkg;

    localparam int SDRAM_ADDR_W = 25;
    localparam int SDRAM_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        WRITE_WAIT,
        READ_WAIT,
        REFRESH
    } sdram_resp_state_t;

    // Largest of three cycle counts; sizes the shared busy counter.
    function automatic int maxOf3(input int a, input int b, input int c);
        int largest;
        largest = a;
        if (b > largest) largest = b;
        if (c > largest) largest = c;
        return largest;
    endfunction

endpackage

// File: rtl/sdram_model_ram.sv
// rtl/sdram_model_ram.sv - single-port synchronous RAM, one write or one registered read per cycle
module sdram_model_ram
    import music_box_sdram_pkg::*;
#(
    parameter int ADDR_BITS = 10,
    parameter int DATA_W    = SDRAM_DATA_W
) (
    input  logic                 clock_50Mhz,
    input  logic                 reset_n,
    input  logic [ADDR_BITS-1:0] address,
    input  logic                 writeEnable,
    input  logic [DATA_W-1:0]    writeData,
    input  logic                 readEnable,
    output logic [DATA_W-1:0]    readData
);

    logic [DATA_W-1:0] memory [2**ADDR_BITS];

    // Array write; contents deliberately survive reset.
    always_ff @(posedge clock_50Mhz) begin
        if (writeEnable) begin
            memory[address] <= writeData;
        end
    end

    // Registered read port; holds the last value read until the next read.
    always_ff @(posedge clock_50Mhz or negedge reset_n) begin
        if (!reset_n) begin
            readData <= '0;
        end else if (readEnable) begin
            readData <= memory[address];
        end
    end

endmodule

// File: rtl/sdram_cmd_responder.sv
// rtl/sdram_cmd_responder.sv - SDRAM command responder backed by on-chip RAM (optional SDRAM_REFRESH_STALL_EN)
module sdram_cmd_responder
    import music_box_sdram_pkg::*;
#(
    parameter int ADDR_BITS        = 10,
    parameter int READ_LATENCY     = 3,
    parameter int WRITE_CYCLES     = 2,
    parameter int REFRESH_INTERVAL = 390,
    parameter int REFRESH_CYCLES   = 8
) (
    input  logic                    clock_50Mhz,
    input  logic                    reset_n,
    input  logic [SDRAM_ADDR_W-1:0] sdram_inputAddress,
    input  logic [SDRAM_DATA_W-1:0] sdram_writeData,
    input  logic                    sdram_isWriting,
    input  logic                    sdram_inputValid,
    output logic [SDRAM_DATA_W-1:0] sdram_readData,
    output logic                    sdram_outputValid,
    output logic                    sdram_recievedCommand,
    output logic                    sdram_isBusy
);

    localparam int COUNT_MAX = maxOf3(READ_LATENCY, WRITE_CYCLES, REFRESH_CYCLES);
    localparam int COUNT_W   = $clog2(COUNT_MAX + 1);

    localparam logic [COUNT_W-1:0] READ_LOAD    = COUNT_W'(READ_LATENCY - 1);
    localparam logic [COUNT_W-1:0] WRITE_LOAD   = COUNT_W'(WRITE_CYCLES - 1);
    localparam logic [COUNT_W-1:0] REFRESH_LOAD = COUNT_W'(REFRESH_CYCLES - 1);

    sdram_resp_state_t      state;
    sdram_resp_state_t      nextState;
    logic [COUNT_W-1:0]     busyCount;
    logic [COUNT_W-1:0]     nextBusyCount;
    logic [ADDR_BITS-1:0]   latchedAddress;
    logic [ADDR_BITS-1:0]   ramAddress;
    logic                   acceptCommand;
    logic                   readFire;
    logic                   refreshRequest;
    logic                   ramWriteEnable;

    // Address bits above the RAM depth alias onto the RAM; they carry no meaning here.
    logic unusedAddressBits;
    assign unusedAddressBits = ^sdram_inputAddress[SDRAM_ADDR_W-1:ADDR_BITS];

`ifdef SDRAM_REFRESH_STALL_EN
    localparam int TIMER_W = $clog2(REFRESH_INTERVAL + 1);

    logic [TIMER_W-1:0] refreshTimer;
    logic               refreshPending;
    logic               refreshDue;

    assign refreshDue     = (refreshTimer == TIMER_W'(REFRESH_INTERVAL - 1));
    assign refreshRequest = refreshPending | refreshDue;

    // Free-running interval timer; a due refresh stays pending until IDLE can take it.
    always_ff @(posedge clock_50Mhz or negedge reset_n) begin
        if (!reset_n) begin
            refreshTimer   <= '0;
            refreshPending <= 1'b0;
        end else begin
            refreshTimer   <= refreshDue ? '0 : refreshTimer + 1'b1;
            refreshPending <= refreshRequest && (state != IDLE);
        end
    end
`else
    localparam int unusedRefreshInterval = REFRESH_INTERVAL;

    assign refreshRequest = 1'b0;
`endif

    // Next-state, busy-count and single-cycle strobes; refresh beats a new command in IDLE.
    always_comb begin
        nextState     = state;
        nextBusyCount = busyCount;
        acceptCommand = 1'b0;
        readFire      = 1'b0;
        case (state)
            IDLE: begin
                if (refreshRequest) begin
                    nextState     = REFRESH;
                    nextBusyCount = REFRESH_LOAD;
                end else if (sdram_inputValid) begin
                    acceptCommand = 1'b1;
                    if (sdram_isWriting) begin
                        nextState     = WRITE_WAIT;
                        nextBusyCount = WRITE_LOAD;
                    end else begin
                        nextState     = READ_WAIT;
                        nextBusyCount = READ_LOAD;
                    end
                end
            end
            WRITE_WAIT: begin
                if (busyCount == '0) begin
                    nextState = IDLE;
                end else begin
                    nextBusyCount = busyCount - 1'b1;
                end
            end
            READ_WAIT: begin
                if (busyCount == '0) begin
                    readFire  = 1'b1;
                    nextState = IDLE;
                end else begin
                    nextBusyCount = busyCount - 1'b1;
                end
            end
            REFRESH: begin
                if (busyCount == '0) begin
                    nextState = IDLE;
                end else begin
                    nextBusyCount = busyCount - 1'b1;
                end
            end
            default: begin
                nextState     = IDLE;
                nextBusyCount = '0;
            end
        endcase
    end

    // State register plus the registered acknowledge and read-complete pulses.
    always_ff @(posedge clock_50Mhz or negedge reset_n) begin
        if (!reset_n) begin
            state                 <= IDLE;
            busyCount             <= '0;
            latchedAddress        <= '0;
            sdram_recievedCommand <= 1'b0;
            sdram_outputValid     <= 1'b0;
        end else begin
            state                 <= nextState;
            busyCount             <= nextBusyCount;
            sdram_recievedCommand <= acceptCommand;
            sdram_outputValid     <= readFire;
            if (acceptCommand) begin
                latchedAddress <= sdram_inputAddress[ADDR_BITS-1:0];
            end
        end
    end

    // Writes land on the accepting edge straight from the inputs; reads use the latched address.
    assign ramWriteEnable = acceptCommand && sdram_isWriting;
    assign ramAddress     = (state == IDLE) ? sdram_inputAddress[ADDR_BITS-1:0] : latchedAddress;
    assign sdram_isBusy   = (state != IDLE);

    sdram_model_ram #(
        .ADDR_BITS (ADDR_BITS),
        .DATA_W    (SDRAM_DATA_W)
    ) modelRam (
        .clock_50Mhz (clock_50Mhz),
        .reset_n     (reset_n),
        .address     (ramAddress),
        .writeEnable (ramWriteEnable),
        .writeData   (sdram_writeData),
        .readEnable  (readFire),
        .readData    (sdram_readData)
    );

endmodule

// File: tb/tb_sdram_cmd_responder.sv
// tb/tb_sdram_cmd_responder.sv - directed and scoreboard bench for sdram_cmd_responder
module tb_sdram_cmd_responder;
    import music_box_sdram_pkg::*;

    localparam int ADDR_BITS        = 10;
    localparam int READ_LATENCY     = 3;
    localparam int WRITE_CYCLES     = 2;
    localparam int REFRESH_INTERVAL = 390;
    localparam int REFRESH_CYCLES   = 8;

    logic                    clock_50Mhz = 1'b0;
    logic                    reset_n;
    logic [SDRAM_ADDR_W-1:0] sdram_inputAddress;
    logic [SDRAM_DATA_W-1:0] sdram_writeData;
    logic                    sdram_isWriting;
    logic                    sdram_inputValid;
    logic [SDRAM_DATA_W-1:0] sdram_readData;
    logic                    sdram_outputValid;
    logic                    sdram_recievedCommand;
    logic                    sdram_isBusy;

    int assertionCount = 0;
    int failureCount   = 0;

    logic [15:0] model [1024];
    bit          written [1024];

    always #10 clock_50Mhz = ~clock_50Mhz;

    sdram_cmd_responder #(
        .ADDR_BITS        (ADDR_BITS),
        .READ_LATENCY     (READ_LATENCY),
        .WRITE_CYCLES     (WRITE_CYCLES),
        .REFRESH_INTERVAL (REFRESH_INTERVAL),
        .REFRESH_CYCLES   (REFRESH_CYCLES)
    ) dut (
        .clock_50Mhz           (clock_50Mhz),
        .reset_n               (reset_n),
        .sdram_inputAddress    (sdram_inputAddress),
        .sdram_writeData       (sdram_writeData),
        .sdram_isWriting       (sdram_isWriting),
        .sdram_inputValid      (sdram_inputValid),
        .sdram_readData        (sdram_readData),
        .sdram_outputValid     (sdram_outputValid),
        .sdram_recievedCommand (sdram_recievedCommand),
        .sdram_isBusy          (sdram_isBusy)
    );

    task automatic assertEqual(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertionCount++;
        if (observed !== expected) begin
            failureCount++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Returns at the falling edge of the acknowledge cycle, or after the bound expires.
    task automatic waitAck(output bit acked);
        acked = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clock_50Mhz);
            if (sdram_recievedCommand) begin
                acked = 1'b1;
                break;
            end
        end
    endtask

    task automatic issue(input bit isWrite, input logic [24:0] addr, input logic [15:0] data, output bit acked);
        @(negedge clock_50Mhz);
        sdram_inputAddress = addr;
        sdram_writeData    = data;
        sdram_isWriting    = isWrite;
        sdram_inputValid   = 1'b1;
        waitAck(acked);
        sdram_inputValid   = 1'b0;
        sdram_isWriting    = 1'b0;
    endtask

    task automatic writeWord(input logic [24:0] addr, input logic [15:0] data);
        bit acked;
        issue(1'b1, addr, data, acked);
        assertEqual("wr_ack", acked, 1);
        assertEqual("wr_busy_c1", sdram_isBusy, 1);
        for (int c = 2; c <= WRITE_CYCLES; c++) begin
            @(negedge clock_50Mhz);
            assertEqual("wr_busy", sdram_isBusy, 1);
            assertEqual("wr_single_ack", sdram_recievedCommand, 0);
        end
        @(negedge clock_50Mhz);
        assertEqual("wr_idle", sdram_isBusy, 0);
    endtask

    task automatic readWord(input logic [24:0] addr, input logic [15:0] expected);
        bit acked;
        issue(1'b0, addr, 16'h0, acked);
        assertEqual("rd_ack", acked, 1);
        assertEqual("rd_busy_c1", sdram_isBusy, 1);
        assertEqual("rd_early_valid", sdram_outputValid, 0);
        for (int c = 2; c <= READ_LATENCY; c++) begin
            @(negedge clock_50Mhz);
            assertEqual("rd_busy", sdram_isBusy, 1);
            assertEqual("rd_early_valid", sdram_outputValid, 0);
        end
        @(negedge clock_50Mhz);
        assertEqual("rd_valid", sdram_outputValid, 1);
        assertEqual("rd_busy_drop", sdram_isBusy, 0);
        assertEqual("rd_data", sdram_readData, expected);
        @(negedge clock_50Mhz);
        assertEqual("rd_valid_pulse", sdram_outputValid, 0);
        assertEqual("rd_data_hold", sdram_readData, expected);
    endtask

    initial begin
        bit          acked;
        int          seen;
        logic [9:0]  addr10;
        logic [24:0] fullAddr;
        logic [15:0] data;

        reset_n            = 1'b0;
        sdram_inputAddress = '0;
        sdram_writeData    = '0;
        sdram_isWriting    = 1'b0;
        sdram_inputValid   = 1'b0;
        repeat (3) @(negedge clock_50Mhz);
        assertEqual("reset_readData", sdram_readData, 0);
        assertEqual("reset_outputValid", sdram_outputValid, 0);
        assertEqual("reset_recievedCommand", sdram_recievedCommand, 0);
        assertEqual("reset_isBusy", sdram_isBusy, 0);
        reset_n = 1'b1;

        // Basic write then read
        writeWord(25'h10, 16'hBEEF);
        readWord(25'h10, 16'hBEEF);

        // inputValid held across the write-busy window
        @(negedge clock_50Mhz);
        sdram_inputAddress = 25'h20;
        sdram_writeData    = 16'h1111;
        sdram_isWriting    = 1'b1;
        sdram_inputValid   = 1'b1;
        waitAck(acked);
        assertEqual("held_first_ack", acked, 1);
        sdram_inputAddress = 25'h21;
        sdram_writeData    = 16'h2222;
        assertEqual("held_busy_c1", sdram_isBusy, 1);
        for (int c = 2; c <= WRITE_CYCLES; c++) begin
            @(negedge clock_50Mhz);
            assertEqual("held_no_ack_busy", sdram_recievedCommand, 0);
            assertEqual("held_busy", sdram_isBusy, 1);
        end
        @(negedge clock_50Mhz);
        assertEqual("held_no_ack_idle", sdram_recievedCommand, 0);
        assertEqual("held_idle", sdram_isBusy, 0);
        @(negedge clock_50Mhz);
        assertEqual("held_second_ack", sdram_recievedCommand, 1);
        assertEqual("held_second_busy", sdram_isBusy, 1);
        sdram_inputValid = 1'b0;
        sdram_isWriting  = 1'b0;
        repeat (WRITE_CYCLES) @(negedge clock_50Mhz);
        assertEqual("held_second_idle", sdram_isBusy, 0);
        readWord(25'h20, 16'h1111);
        readWord(25'h21, 16'h2222);

        // Address wrap and top-address alias
        writeWord(25'h0000400, 16'h1234);
        readWord(25'h0000000, 16'h1234);
        writeWord(25'h3FF, 16'hA5A5);
        readWord(25'h1FFFFFF, 16'hA5A5);

        // readData held through a write and idle time
        writeWord(25'h5, 16'h0F0F);
        repeat (4) @(negedge clock_50Mhz);
        assertEqual("hold_after_write", sdram_readData, 16'hA5A5);

        // Reset in C2 of a read
        writeWord(25'h30, 16'hCAFE);
        issue(1'b0, 25'h30, 16'h0, acked);
        assertEqual("abort_ack", acked, 1);
        @(negedge clock_50Mhz);
        reset_n = 1'b0;
        #1;
        assertEqual("abort_outputValid", sdram_outputValid, 0);
        assertEqual("abort_recievedCommand", sdram_recievedCommand, 0);
        assertEqual("abort_isBusy", sdram_isBusy, 0);
        assertEqual("abort_readData", sdram_readData, 0);
        repeat (2) @(negedge clock_50Mhz);
        reset_n = 1'b1;
        seen = 0;
        for (int c = 0; c < READ_LATENCY + 3; c++) begin
            @(negedge clock_50Mhz);
            if (sdram_outputValid) seen++;
        end
        assertEqual("abort_no_valid", seen, 0);
        readWord(25'h30, 16'hCAFE);

        // Random traffic against a scoreboard
        for (int i = 0; i < 1024; i++) written[i] = 1'b0;
        for (int i = 0; i < 256; i++) begin
            addr10   = 10'($urandom_range(0, 63));
            fullAddr = {15'($urandom), addr10};
            if ($urandom_range(0, 1) == 1 && written[addr10]) begin
                readWord(fullAddr, model[addr10]);
            end else begin
                data = 16'($urandom);
                writeWord(fullAddr, data);
                model[addr10]   = data;
                written[addr10] = 1'b1;
            end
        end

`ifdef SDRAM_REFRESH_STALL_EN
        // Command arriving in the same cycle the refresh becomes due
        @(negedge clock_50Mhz);
        reset_n = 1'b0;
        @(negedge clock_50Mhz);
        reset_n = 1'b1;
        repeat (REFRESH_INTERVAL - 1) @(posedge clock_50Mhz);
        @(negedge clock_50Mhz);
        sdram_inputAddress = 25'h40;
        sdram_writeData    = 16'h5A5A;
        sdram_isWriting    = 1'b1;
        sdram_inputValid   = 1'b1;
        for (int c = 0; c < REFRESH_CYCLES; c++) begin
            @(negedge clock_50Mhz);
            assertEqual("refresh_busy", sdram_isBusy, 1);
            assertEqual("refresh_no_ack", sdram_recievedCommand, 0);
        end
        @(negedge clock_50Mhz);
        assertEqual("refresh_idle", sdram_isBusy, 0);
        @(negedge clock_50Mhz);
        assertEqual("refresh_then_ack", sdram_recievedCommand, 1);
        sdram_inputValid = 1'b0;
        sdram_isWriting  = 1'b0;
        repeat (WRITE_CYCLES) @(negedge clock_50Mhz);
        readWord(25'h40, 16'h5A5A);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assertionCount, failureCount);
        $finish;
    end

endmodule
